// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem: AXI4 slave backed by a word memory, FIXED/INCR/WRAP bursts, byte strobes,
// independent write and read FSMs with one outstanding burst per direction.
module ei_axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [1:0]              awburst,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [1:0]              arburst,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int OFF  = $clog2(STRB);
  localparam int IW   = $clog2(MEM_DEPTH);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  // Reserved bursts and illegal WRAP lengths fall back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] len);
    return (b == 2'b11 || (b == 2'b10 && !wrap_len_ok(len))) ? 2'b01 : b;
  endfunction

  function automatic logic burst_err(input logic [1:0] b, input logic [7:0] len, input logic [2:0] size);
    return b == 2'b11 || (b == 2'b10 && !wrap_len_ok(len)) || (32'd1 << size) > 32'(STRB);
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] b);
    addr_t inc, al, wmask;
    inc   = addr_t'(1) << size;
    al    = a & ~(inc - addr_t'(1));
    wmask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    return b == 2'b00 ? a : b == 2'b10 ? (a & ~wmask) | ((al + inc) & wmask) : al + inc;
  endfunction

  function automatic logic oor(input addr_t a);
    return (a >> OFF) >= addr_t'(MEM_DEPTH);
  endfunction

  function automatic logic [IW-1:0] widx(input addr_t a);
    return a[OFF +: IW];
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t         wst_q;
  addr_t           waddr_q;
  logic [7:0]      wlen_q, wbeat_q;
  logic [2:0]      wsize_q;
  logic [1:0]      wburst_q, bresp_q;
  logic            werr_q, awready_q, wready_q, bvalid_q;
  logic            w_fire, w_end, w_bad;

  assign w_fire  = wvalid && wready_q;
  assign w_end   = wbeat_q == wlen_q;
  assign w_bad   = oor(waddr_q) || (wlast != w_end);
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wbeat_q   <= 8'd0;
      wsize_q   <= 3'd0;
      wburst_q  <= 2'b00;
      werr_q    <= 1'b0;
    end else begin
      case (wst_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            waddr_q   <= awaddr;
            wlen_q    <= awlen;
            wsize_q   <= awsize;
            wburst_q  <= eff_burst(awburst, awlen);
            werr_q    <= burst_err(awburst, awlen, awsize);
            wbeat_q   <= 8'd0;
            wst_q     <= W_DATA;
          end
        end
        W_DATA: if (w_fire) begin
          wbeat_q <= wbeat_q + 8'd1;
          waddr_q <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
          werr_q  <= werr_q || w_bad;
          if (w_end) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (werr_q || w_bad) ? 2'b10 : 2'b00;
            wst_q    <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wst_q     <= W_IDLE;
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // wready drops asynchronously with reset, so an aborted burst commits nothing further.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < STRB; b++)
      if (w_fire && wstrb[b] && !oor(waddr_q))
        mem[widx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  rstate_t               rst_q;
  addr_t                 raddr_q, r_src;
  logic [7:0]            rlen_q, rbeat_q, r_len, r_nbeat;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q, rresp_q;
  logic                  rerr_q, arready_q, rvalid_q, rlast_q, r_berr, r_start, r_load;
  logic [DATA_WIDTH-1:0] rdata_q, r_word;

  assign r_start = rst_q == R_IDLE && arvalid && arready_q;
  assign r_load  = r_start || (rst_q == R_DATA && rready && !rlast_q);
  assign r_src   = rst_q == R_IDLE ? araddr : raddr_q;
  assign r_len   = rst_q == R_IDLE ? arlen : rlen_q;
  assign r_nbeat = rst_q == R_IDLE ? 8'd0 : rbeat_q + 8'd1;
  assign r_berr  = rst_q == R_IDLE ? burst_err(arburst, arlen, arsize) : rerr_q;
  // Sampled before this edge's write lands, so a colliding read sees the old word.
  assign r_word  = oor(r_src) ? '0 : mem[widx(r_src)];
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= 2'b00;
      rerr_q    <= 1'b0;
    end else begin
      if (r_load) begin
        rdata_q  <= r_word;
        rresp_q  <= (r_berr || oor(r_src)) ? 2'b10 : 2'b00;
        rlast_q  <= r_nbeat == r_len;
        rbeat_q  <= r_nbeat;
        rvalid_q <= 1'b1;
      end
      case (rst_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (r_start) begin
            arready_q <= 1'b0;
            rlen_q    <= arlen;
            rsize_q   <= arsize;
            rburst_q  <= eff_burst(arburst, arlen);
            rerr_q    <= burst_err(arburst, arlen, arsize);
            raddr_q   <= next_addr(araddr, arsize, arlen, eff_burst(arburst, arlen));
            rst_q     <= R_DATA;
          end
        end
        R_DATA: if (rready && rlast_q) begin
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          arready_q <= 1'b1;
          rst_q     <= R_IDLE;
        end else if (rready) begin
          raddr_q <= next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
        end
      endcase
    end
  end
endmodule
